// File: rtl/stream_out.sv
// Output stage toward the DMA: buffers upsampled pixels in a small FIFO and
// streams them as an AXI-Stream master, marking the final beat of each frame.
module stream_out #(
    parameter int AXIS_DATA_WIDTH = 32,
    parameter int UPSP_DATA_WIDTH = 24,
    parameter int FIFO_DEPTH      = 16,
    parameter int IMG_WIDTH       = 3840,
    parameter int IMG_HEIGHT      = 2160
) (
    input  logic                         m_axis_aclk,
    input  logic                         m_axis_arst,
    input  logic                         UPSTR,
    input  logic                         upsp_ac_wr,
    input  logic [UPSP_DATA_WIDTH-1:0]   upsp_ac_wdata,
    output logic                         ac_upsp_wready,
    output logic                         ac_frame_done,
    output logic                         ac_wr_err,
    output logic                         m_axis_tvalid,
    input  logic                         m_axis_tready,
    output logic [AXIS_DATA_WIDTH-1:0]   m_axis_tdata,
    output logic [AXIS_DATA_WIDTH/8-1:0] m_axis_tstrb,
    output logic [AXIS_DATA_WIDTH/8-1:0] m_axis_tkeep,
    output logic                         m_axis_tlast
);

    localparam int TOTAL = IMG_WIDTH * IMG_HEIGHT;
    localparam int CNT_W = $clog2(TOTAL + 1);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int FCW   = PTR_W + 1;

    typedef enum logic [1:0] {
        IDLE,
        STREAM,
        DONE
    } state_t;

    state_t state;
    state_t state_next;

    logic [UPSP_DATA_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]           wr_ptr;
    logic [PTR_W-1:0]           rd_ptr;
    logic [FCW-1:0]             count;
    logic [CNT_W-1:0]           wr_cnt;
    logic [CNT_W-1:0]           rd_cnt;
    logic                       wr_err;
    logic                       start;
    logic                       wr_fire;
    logic                       rd_fire;

    assign start   = (state != STREAM) & UPSTR;
    assign wr_fire = upsp_ac_wr & ac_upsp_wready;
    assign rd_fire = m_axis_tvalid & m_axis_tready;

    assign ac_upsp_wready = (state == STREAM)
                          & (count < FCW'(FIFO_DEPTH))
                          & (wr_cnt < CNT_W'(TOTAL));
    assign ac_frame_done  = (state == DONE);
    assign ac_wr_err      = wr_err;

    // Data is gated by valid so the bus reads zero whenever the FIFO is empty.
    assign m_axis_tvalid = (count != '0);
    assign m_axis_tdata  = m_axis_tvalid ? AXIS_DATA_WIDTH'(mem[rd_ptr]) : '0;
    assign m_axis_tlast  = m_axis_tvalid & (rd_cnt == CNT_W'(TOTAL - 1));
    assign m_axis_tstrb  = '1;
    assign m_axis_tkeep  = '1;

    always_ff @(posedge m_axis_aclk or posedge m_axis_arst) begin
        if (m_axis_arst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (UPSTR) state_next = STREAM;
            STREAM:  if (rd_fire && m_axis_tlast) state_next = DONE;
            DONE:    if (UPSTR) state_next = STREAM;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge m_axis_aclk or posedge m_axis_arst) begin
        if (m_axis_arst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_fire) wr_ptr <= wr_ptr + PTR_W'(1);
            if (rd_fire) rd_ptr <= rd_ptr + PTR_W'(1);
            case ({wr_fire, rd_fire})
                2'b10:   count <= count + FCW'(1);
                2'b01:   count <= count - FCW'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset; emptiness is tracked by count alone.
    always_ff @(posedge m_axis_aclk) begin
        if (wr_fire) mem[wr_ptr] <= upsp_ac_wdata;
    end

    always_ff @(posedge m_axis_aclk or posedge m_axis_arst) begin
        if (m_axis_arst) begin
            wr_cnt <= '0;
            rd_cnt <= '0;
            wr_err <= 1'b0;
        end else if (start) begin
            wr_cnt <= '0;
            rd_cnt <= '0;
            wr_err <= 1'b0;
        end else begin
            if (wr_fire) wr_cnt <= wr_cnt + CNT_W'(1);
            if (rd_fire) rd_cnt <= rd_cnt + CNT_W'(1);
            if (upsp_ac_wr && !ac_upsp_wready) wr_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_stream_out.sv
// Self-checking bench for stream_out with a cycle model and scoreboard queue
// using a tiny 4x2 frame and a 4-entry FIFO.
module tb_stream_out;

    localparam int AW    = 32;
    localparam int UW    = 24;
    localparam int DEPTH = 4;
    localparam int TOTAL = 8;

    logic          clk;
    logic          rst;
    logic          upstr;
    logic          wr;
    logic [UW-1:0] wdata;
    logic          wready;
    logic          frame_done;
    logic          wr_err;
    logic          tvalid;
    logic          tready;
    logic [AW-1:0] tdata;
    logic [3:0]    tstrb;
    logic [3:0]    tkeep;
    logic          tlast;

    int check_count = 0;
    int pass_count  = 0;
    int beats       = 0;

    // Reference model: state 0=IDLE 1=STREAM 2=DONE; queue length is the FIFO count.
    logic [UW-1:0] exp_q[$];
    int            m_state = 0;
    int            m_wr    = 0;
    int            m_rd    = 0;
    bit            m_err   = 0;

    stream_out #(
        .AXIS_DATA_WIDTH(AW),
        .UPSP_DATA_WIDTH(UW),
        .FIFO_DEPTH     (DEPTH),
        .IMG_WIDTH      (4),
        .IMG_HEIGHT     (2)
    ) dut (
        .m_axis_aclk   (clk),
        .m_axis_arst   (rst),
        .UPSTR         (upstr),
        .upsp_ac_wr    (wr),
        .upsp_ac_wdata (wdata),
        .ac_upsp_wready(wready),
        .ac_frame_done (frame_done),
        .ac_wr_err     (wr_err),
        .m_axis_tvalid (tvalid),
        .m_axis_tready (tready),
        .m_axis_tdata  (tdata),
        .m_axis_tstrb  (tstrb),
        .m_axis_tkeep  (tkeep),
        .m_axis_tlast  (tlast)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        check_count++;
        if (got === exp) begin
            pass_count++;
        end else begin
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit model_wready();
        return (m_state == 1) && (exp_q.size() < DEPTH) && (m_wr < TOTAL);
    endfunction

    // Cycle model evaluated mid-cycle; it predicts the effect of the next rising edge.
    always @(negedge clk) begin
        bit m_valid, m_rdy, m_last, wacc, rd;
        if (rst) begin
            checkOutput("rst_tvalid", {31'b0, tvalid}, 0);
            checkOutput("rst_wready", {31'b0, wready}, 0);
            checkOutput("rst_done", {31'b0, frame_done}, 0);
            checkOutput("rst_err", {31'b0, wr_err}, 0);
            checkOutput("rst_tdata", tdata, 0);
            checkOutput("rst_tlast", {31'b0, tlast}, 0);
            exp_q.delete();
            m_state = 0;
            m_wr    = 0;
            m_rd    = 0;
            m_err   = 0;
        end else begin
            m_valid = (exp_q.size() != 0);
            m_rdy   = model_wready();
            m_last  = m_valid && (m_rd == TOTAL - 1);
            checkOutput("cyc_wready", {31'b0, wready}, {31'b0, m_rdy});
            checkOutput("cyc_tvalid", {31'b0, tvalid}, {31'b0, m_valid});
            checkOutput("cyc_done", {31'b0, frame_done}, {31'b0, m_state == 2});
            checkOutput("cyc_err", {31'b0, wr_err}, {31'b0, m_err});
            checkOutput("cyc_tdata", tdata, m_valid ? 32'(exp_q[0]) : 32'h0);
            checkOutput("cyc_tlast", {31'b0, tlast}, {31'b0, m_last});
            wacc = wr && m_rdy;
            rd   = m_valid && tready;
            if (rd) begin
                checkOutput("beat_tkeep", {28'b0, tkeep}, 32'hF);
                checkOutput("beat_tstrb", {28'b0, tstrb}, 32'hF);
                void'(exp_q.pop_front());
                beats++;
                m_rd++;
            end
            if (wacc) begin
                exp_q.push_back(wdata);
                m_wr++;
            end
            if (wr && !m_rdy) m_err = 1;
            if (m_state != 1 && upstr) begin
                m_state = 1;
                m_wr    = 0;
                m_rd    = 0;
                m_err   = 0;
            end else if (m_state == 1 && rd && m_last) begin
                m_state = 2;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic startFrame();
        beats = 0;
        upstr = 1'b1;
        step();
        upstr = 1'b0;
    endtask

    // Hold off until the model can accept, then write one pixel.
    task automatic applyStimulus(input logic [UW-1:0] d);
        int n = 0;
        wr = 1'b0;
        while (!model_wready() && n < 30) begin
            step();
            n++;
        end
        if (n >= 30) checkOutput("wready_timeout", 0, 1);
        wr    = 1'b1;
        wdata = d;
        step();
        wr    = 1'b0;
    endtask

    task automatic waitFrame(input string tag);
        int n = 0;
        while (!(m_state == 2 && exp_q.size() == 0) && n < 40) begin
            step();
            n++;
        end
        if (n >= 40) checkOutput({tag, "_timeout"}, 0, 1);
        checkOutput({tag, "_done"}, {31'b0, frame_done}, 1);
        checkOutput({tag, "_beats"}, beats, TOTAL);
    endtask

    task automatic pulseReset();
        rst = 1'b1;
        step();
        rst = 1'b0;
        step();
    endtask

    initial begin
        rst    = 1'b1;
        upstr  = 1'b0;
        wr     = 1'b0;
        wdata  = '0;
        tready = 1'b0;
        step();
        step();
        rst = 1'b0;
        step();

        // No backpressure: one beat per pixel, tlast on the eighth.
        startFrame();
        tready = 1'b1;
        for (int i = 1; i <= TOTAL; i++) applyStimulus(UW'(i));
        waitFrame("nobp");

        // Stall the sink: FIFO fills at four, extra attempts are dropped.
        startFrame();
        tready = 1'b0;
        for (int i = 1; i <= 6; i++) begin
            wr    = 1'b1;
            wdata = UW'(i);
            step();
        end
        wr = 1'b0;
        checkOutput("full_wready", {31'b0, wready}, 0);
        checkOutput("full_tvalid", {31'b0, tvalid}, 1);
        checkOutput("full_tdata", tdata, 32'h1);
        checkOutput("full_err", {31'b0, wr_err}, 1);
        tready = 1'b1;
        for (int i = 5; i <= TOTAL; i++) applyStimulus(UW'(i));
        waitFrame("full");

        // Simultaneous read and write with three entries held.
        startFrame();
        tready = 1'b0;
        for (int i = 1; i <= 3; i++) applyStimulus(UW'(32'h100 + i));
        tready = 1'b1;
        applyStimulus(UW'(32'h104));
        checkOutput("simul_wready", {31'b0, wready}, 1);
        checkOutput("simul_tdata", tdata, 32'h102);
        for (int i = 5; i <= TOTAL; i++) applyStimulus(UW'(32'h100 + i));
        waitFrame("simul");

        // Write while idle flags an error and emits nothing; a frame start clears it.
        pulseReset();
        tready = 1'b1;
        wr     = 1'b1;
        wdata  = 24'hAAAAAA;
        step();
        wr = 1'b0;
        step();
        checkOutput("idle_err", {31'b0, wr_err}, 1);
        checkOutput("idle_tvalid", {31'b0, tvalid}, 0);
        startFrame();
        checkOutput("start_clr_err", {31'b0, wr_err}, 0);
        for (int i = 1; i <= TOTAL; i++) applyStimulus(UW'(32'hABC000 + i));

        // A ninth write after the whole frame was accepted is refused.
        checkOutput("over_wready", {31'b0, wready}, 0);
        wr    = 1'b1;
        wdata = 24'h999999;
        step();
        wr = 1'b0;
        checkOutput("over_err", {31'b0, wr_err}, 1);
        waitFrame("over");

        // Asynchronous reset mid-frame, then a clean frame.
        startFrame();
        for (int i = 1; i <= 4; i++) applyStimulus(UW'(32'h200 + i));
        rst = 1'b1;
        #1;
        checkOutput("arst_tvalid", {31'b0, tvalid}, 0);
        checkOutput("arst_tdata", tdata, 0);
        checkOutput("arst_tlast", {31'b0, tlast}, 0);
        checkOutput("arst_wready", {31'b0, wready}, 0);
        checkOutput("arst_done", {31'b0, frame_done}, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        step();
        startFrame();
        for (int i = 1; i <= TOTAL; i++) applyStimulus(UW'(32'h300 + i));
        waitFrame("after_rst");

        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule
